gauss_frame_sequencer: RTL and testbench



---
 rtl/gauss_frame_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_gauss_frame_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_frame_sequencer.sv
// ============================================================================
// gauss_frame_sequencer
//   Raster-scans a source frame, feeds each 3x3 window to the Gaussian filter
//   peripheral, polls for completion and writes the result to a destination.
//   Optional build macro: GAUSS_SEQ_TIMEOUT_EN (poll timeout with sticky err).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module gauss_frame_sequencer #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_rdata,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_wdata,
    output logic              out_we,
    output logic              g_select,
    output logic              g_we,
    output logic [31:0]       g_wdata,
    input  logic [31:0]       g_rdata
);

    localparam logic [ADDR_W-1:0] SRC_W  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] DST_W  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_LOAD  = 4'd2,
        S_KICK  = 4'd3,
        S_POLL  = 4'd4,
        S_READ  = 4'd5,
        S_STORE = 4'd6,
        S_NEXT  = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [1:0]        dr_q, dr_d;
    logic [1:0]        dc_q, dc_d;
    logic              first_q, first_d;
    logic [7:0]        pix_q, pix_d;
`ifdef GAUSS_SEQ_TIMEOUT_EN
    logic [7:0]        tmo_q, tmo_d;
    logic              err_q, err_d;
`endif

    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              unused_rdata;

    assign src_addr = (r_q + {{(ADDR_W-2){1'b0}}, dr_q}) * SRC_W
                    + c_q + {{(ADDR_W-2){1'b0}}, dc_q};
    assign dst_addr = r_q * DST_W + c_q;
    assign unused_rdata = ^g_rdata[31:8];

`ifdef GAUSS_SEQ_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            dr_q    <= 2'd0;
            dc_q    <= 2'd0;
            first_q <= 1'b0;
            pix_q   <= 8'd0;
`ifdef GAUSS_SEQ_TIMEOUT_EN
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            dr_q    <= dr_d;
            dc_q    <= dc_d;
            first_q <= first_d;
            pix_q   <= pix_d;
`ifdef GAUSS_SEQ_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        dr_d      = dr_q;
        dc_d      = dc_q;
        first_d   = first_q;
        pix_d     = pix_q;
`ifdef GAUSS_SEQ_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = 1'b0;
        img_addr  = '0;
        out_addr  = '0;
        out_wdata = 8'd0;
        out_we    = 1'b0;
        g_select  = 1'b0;
        g_we      = 1'b0;
        g_wdata   = 32'd0;

        case (state_q)
            S_IDLE: begin
                r_d  = '0;
                c_d  = '0;
                dr_d = 2'd0;
                dc_d = 2'd0;
                if (start) begin
                    state_d = S_FETCH;
`ifdef GAUSS_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                img_addr = src_addr;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                g_select = 1'b1;
                g_we     = 1'b1;
                g_wdata  = {24'd0, img_rdata};
                if (dr_q == 2'd2 && dc_q == 2'd2) begin
                    dr_d    = 2'd0;
                    dc_d    = 2'd0;
                    state_d = S_KICK;
                end else if (dc_q == 2'd2) begin
                    dc_d    = 2'd0;
                    dr_d    = dr_q + 2'd1;
                    state_d = S_FETCH;
                end else begin
                    dc_d    = dc_q + 2'd1;
                    state_d = S_FETCH;
                end
            end
            S_KICK: begin
                g_we    = 1'b1;
                g_wdata = 32'h1;
                first_d = 1'b1;
`ifdef GAUSS_SEQ_TIMEOUT_EN
                tmo_d   = 8'd0;
`endif
                state_d = S_POLL;
            end
            S_POLL: begin
                // The peripheral's busy flag may not yet reflect the kick on
                // the first poll cycle, so that sample is discarded.
                first_d = 1'b0;
`ifdef GAUSS_SEQ_TIMEOUT_EN
                tmo_d   = tmo_q + 8'd1;
`endif
                if (!first_q && !g_rdata[0]) begin
                    state_d = S_READ;
`ifdef GAUSS_SEQ_TIMEOUT_EN
                end else if (tmo_q == 8'd254) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
`endif
                end
            end
            S_READ: begin
                g_select = 1'b1;
                pix_d    = g_rdata[7:0];
                state_d  = S_STORE;
            end
            S_STORE: begin
                out_we    = 1'b1;
                out_addr  = dst_addr;
                out_wdata = pix_q;
                state_d   = S_NEXT;
            end
            S_NEXT: begin
                if (c_q == C_LAST) begin
                    c_d = '0;
                    if (r_q == R_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        r_d     = r_q + ONE_A;
                        state_d = S_FETCH;
                    end
                end else begin
                    c_d     = c_q + ONE_A;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_gauss_frame_sequencer.sv
// ============================================================================
// tb_gauss_frame_sequencer
//   Randomised frames checked against an arithmetic 3x3 Gaussian model, with a
//   behavioural filter peripheral on the register bus.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gauss_frame_sequencer;

    localparam int W         = 6;
    localparam int H         = 5;
    localparam int AW        = 10;
    localparam int OW        = W - 2;
    localparam int OH        = H - 2;
    localparam int NPIX      = OW * OH;
    localparam int BUSY_LEN  = 3;
    // 18 fetch/load + kick + poll(BUSY_LEN busy samples + 1 clear) + read/store/next
    localparam int PIX_CYC   = 18 + 1 + (BUSY_LEN + 1) + 3;
    localparam int FRAME_CYC = NPIX * PIX_CYC + 1;
    localparam int WAIT_LIM  = 2 * FRAME_CYC + 600;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_rdata = 8'd0;
    logic [AW-1:0] out_addr;
    logic [7:0]    out_wdata;
    logic          out_we;
    logic          g_select, g_we;
    logic [31:0]   g_wdata, g_rdata;

    always #5 clk = ~clk;

    gauss_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .img_addr(img_addr), .img_rdata(img_rdata),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_we(out_we),
        .g_select(g_select), .g_we(g_we), .g_wdata(g_wdata), .g_rdata(g_rdata)
    );

    // ---------------- source memory (1-cycle synchronous read) ----------------
    logic [7:0] src [W*H];

    function automatic logic [7:0] src_rd(logic [AW-1:0] a);
        if (int'(a) < W*H) return src[int'(a)];
        return 8'h00;
    endfunction

    always @(posedge clk) img_rdata <= src_rd(img_addr);

    // ---------------- behavioural filter peripheral ----------------
    logic [7:0] taps [9];
    logic [7:0] pres = 8'd0;
    int         wptr = 0, pcnt = 0, kicks = 0;
    logic       stuck = 1'b0;
    int         stuck_kick = -1;

    function automatic logic [7:0] filt();
        int s = 0;
        int wt[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        for (int k = 0; k < 9; k++) s += wt[k] * int'(taps[k]);
        return 8'(s >> 4);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            wptr <= 0; pcnt <= 0; pres <= 8'd0; stuck <= 1'b0; kicks <= 0;
        end else if (g_we && g_select) begin
            taps[wptr] <= g_wdata[7:0];
            wptr       <= (wptr + 1) % 9;
        end else if (g_we && !g_select && g_wdata[0]) begin
            pres  <= filt();
            pcnt  <= BUSY_LEN;
            wptr  <= 0;
            stuck <= (kicks == stuck_kick);
            kicks <= kicks + 1;
        end else if (pcnt > 0) begin
            pcnt <= pcnt - 1;
        end
        if (!rst && start && !busy) kicks <= 0;
    end

    assign g_rdata = g_select ? {24'h0, pres} : {31'h0, (pcnt != 0) || stuck};

    // ---------------- monitor ----------------
    int         cyc = 0;
    logic [AW-1:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] gw_q[$];
    int         done_cnt = 0, done_cyc = 0, strobe_viol = 0;
    logic       busy_at_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_we) begin
                wa_q.push_back(out_addr);
                wd_q.push_back(out_wdata);
            end
            if (g_we && g_select) gw_q.push_back(g_wdata[7:0]);
            if (done) begin
                done_cnt     <= done_cnt + 1;
                done_cyc     <= cyc;
                busy_at_done <= busy;
            end
            if (int'(out_we) + int'(g_we) + int'(done) > 1) strobe_viol <= strobe_viol + 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic int exp_pix(int r, int c);
        int s = 0;
        int wt[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        for (int k = 0; k < 9; k++) s += wt[k] * int'(src[(r + k/3)*W + c + k%3]);
        return s >> 4;
    endfunction

    function automatic int written(int base, int addr);
        for (int i = base; i < wa_q.size(); i++)
            if (int'(wa_q[i]) == addr) return int'(wd_q[i]);
        return -1;
    endfunction

    int n_pass = 0, n_total = 0;

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < W*H; i++) src[i] = 8'($urandom_range(0, 255));
    endtask

    // Runs one frame and checks writes, window loads, done/busy/err and latency.
    task automatic run_frame(string tag, int skip, bit chk_lat, bit spam);
        int wb = wa_q.size();
        int gb = gw_q.size();
        int db = done_cnt;
        int s  = cyc;
        int lim = 0;
        int j = 0;
        int nexp = (skip >= 0) ? NPIX - 1 : NPIX;
        pulse_start();
        n_total++;
        if (busy !== 1'b1 || err !== 1'b0)
            $display("FAIL %s start_ack: busy=%b err=%b, required busy=1 err=0", tag, busy, err);
        else n_pass++;
        while (done_cnt == db && lim < WAIT_LIM) begin
            @(negedge clk);
            lim++;
            start = (spam && (lim % 37 == 5)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        tick(3);
        n_total++;
        if (done_cnt - db !== 1)
            $display("FAIL %s done_count: got %0d, required 1", tag, done_cnt - db);
        else n_pass++;
        n_total++;
        if (busy_at_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s busy_fall: busy_at_done=%b busy=%b, required 0", tag, busy_at_done, busy);
        else n_pass++;
        n_total++;
        if (err !== (skip >= 0))
            $display("FAIL %s err_end: got %b, required %b", tag, err, skip >= 0);
        else n_pass++;
        if (chk_lat) begin
            n_total++;
            if (done_cyc - s !== FRAME_CYC)
                $display("FAIL %s latency: got %0d, required %0d", tag, done_cyc - s, FRAME_CYC);
            else n_pass++;
        end
        n_total++;
        if (wa_q.size() - wb !== nexp)
            $display("FAIL %s write_count: got %0d, required %0d", tag, wa_q.size() - wb, nexp);
        else n_pass++;
        for (int p = 0; p < NPIX && wb + j < wa_q.size(); p++) begin
            if (p == skip) continue;
            n_total++;
            if (int'(wa_q[wb+j]) !== p || int'(wd_q[wb+j]) !== exp_pix(p / OW, p % OW))
                $display("FAIL %s write[%0d]: addr=%0d data=%0d, required addr=%0d data=%0d",
                         tag, j, wa_q[wb+j], wd_q[wb+j], p, exp_pix(p / OW, p % OW));
            else n_pass++;
            j++;
        end
        n_total++;
        if (gw_q.size() - gb !== 9*NPIX)
            $display("FAIL %s load_count: got %0d, required %0d", tag, gw_q.size() - gb, 9*NPIX);
        else n_pass++;
        for (int n = 0; n < 9*NPIX && gb + n < gw_q.size(); n++) begin
            int p = n / 9, k = n % 9;
            int ev = int'(src[(p/OW + k/3)*W + p%OW + k%3]);
            n_total++;
            if (int'(gw_q[gb+n]) !== ev)
                $display("FAIL %s load[%0d]: got %0d, required %0d", tag, n, gw_q[gb+n], ev);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        tick(3);
        n_total++;
        if ({busy, done, err, out_we, g_we, g_select, img_addr, out_addr, out_wdata, g_wdata} !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b err=%b out_we=%b g_we=%b g_sel=%b img_addr=%0d out_addr=%0d wdata=%0d g_wdata=%0h, required all 0",
                     busy, done, err, out_we, g_we, g_select, img_addr, out_addr, out_wdata, g_wdata);
        else n_pass++;
        start = 1'b0;
        rst = 1'b0;
        tick(4);
        n_total++;
        if (busy !== 1'b0 || wa_q.size() !== 0)
            $display("FAIL start_during_rst: busy=%b writes=%0d, required 0 and 0", busy, wa_q.size());
        else n_pass++;
    endtask

    task automatic test_uniform();
        for (int i = 0; i < W*H; i++) src[i] = 8'd100;
        run_frame("uniform", -1, 1'b1, 1'b0);
    endtask

    task automatic test_window_order();
        int gb = gw_q.size();
        int exp_win[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
        for (int i = 0; i < W*H; i++) src[i] = 8'(i);
        run_frame("window", -1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            n_total++;
            if (gb + k >= gw_q.size() || int'(gw_q[gb+k]) !== exp_win[k])
                $display("FAIL window_first[%0d]: got %0d, required %0d", k,
                         (gb + k < gw_q.size()) ? int'(gw_q[gb+k]) : -1, exp_win[k]);
            else n_pass++;
        end
    endtask

    task automatic test_impulse();
        int wb = wa_q.size();
        int addr[5] = '{5, 1, 4, 0, 3};
        int val[5]  = '{40, 20, 20, 10, 0};
        for (int i = 0; i < W*H; i++) src[i] = 8'd0;
        src[2*W + 2] = 8'd160;
        run_frame("impulse", -1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (written(wb, addr[i]) !== val[i])
                $display("FAIL impulse_addr%0d: got %0d, required %0d", addr[i], written(wb, addr[i]), val[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame("random", -1, 1'b1, 1'b0);
        end
    endtask

    task automatic test_start_while_busy();
        fill_random();
        run_frame("start_busy", -1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_poll();
        int lim = 0;
        int wb;
        fill_random();
        pulse_start();
        while (kicks < 2 && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        n_total++;
        if (kicks != 2)
            $display("FAIL midpoll_reach: kicks=%0d, required 2", kicks);
        else n_pass++;
        wb = wa_q.size();
        rst = 1'b1;
        tick(1);
        n_total++;
        if ({busy, done, err, out_we, g_we, g_select, img_addr, out_addr, out_wdata, g_wdata} !== '0)
            $display("FAIL midpoll_outputs: busy=%b g_we=%b g_sel=%b out_we=%b img_addr=%0d, required all 0",
                     busy, g_we, g_select, out_we, img_addr);
        else n_pass++;
        tick(1);
        rst = 1'b0;
        tick(40);
        n_total++;
        if (wa_q.size() !== wb || busy !== 1'b0)
            $display("FAIL midpoll_quiet: writes=%0d busy=%b, required %0d and 0", wa_q.size(), busy, wb);
        else n_pass++;
        fill_random();
        run_frame("after_reset", -1, 1'b1, 1'b0);
    endtask

`ifdef GAUSS_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        fill_random();
        stuck_kick = 1;
        run_frame("timeout", 1, 1'b0, 1'b0);
        stuck_kick = -1;
        fill_random();
        run_frame("timeout_clear", -1, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        for (int i = 0; i < W*H; i++) src[i] = 8'd0;
        for (int k = 0; k < 9; k++) taps[k] = 8'd0;
        @(negedge clk);
        test_reset();
        test_uniform();
        test_window_order();
        test_impulse();
        test_random();
        test_start_while_busy();
        test_reset_mid_poll();
`ifdef GAUSS_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        n_total++;
        if (strobe_viol !== 0)
            $display("FAIL strobe_exclusive: got %0d overlapping cycles, required 0", strobe_viol);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
